control_sequencer: RTL
======================

# control_sequencer

Hardwired control unit for the 32-bit bus-based CPU. It runs the instruction cycle (fetch, decode, execute) and drives every control strobe the datapath consumes: bus-source selects, register enables, ALU operation, memory Read/Write, and the GRA/GRB/GRC/Rin/Rout/BAout/CON_in fields. It is a Moore-style step counter plus opcode decode. Its inputs are IR and the CON flip-flop result, both returned from the datapath.

## Interface
Parameters:
- ADD_OP, 5'b00011, ALU code driven for address and branch-target additions.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-low reset.
- IR  in  32  instruction register contents. Fields:
  - opcode = IR[31:27]
  - Ra = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
- CON_output  in  1  branch condition result from the CON flip-flop.
- stop  in  1  request to halt at the next instruction boundary.
- Bus sources, each out 1: PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortout.
- Register loads, each out 1: MAR_enable, PC_enable, IncPC, MDR_enable, IR_enable, Y_enable, Z_low_enable, Z_high_enable, HI_enable, LO_enable, Output_port_enable, R15_enable.
- Memory strobes, each out 1: Read, Write.
- Register-select fields, each out 1: GRA, GRB, GRC, Rin, Rout, BAout, CON_in.
- operation  out  5  ALU opcode.
- run  out  1  high while executing; low in HALT.

## Operation
- State is a step register: T0–T7 plus HALT. All outputs are decoded combinationally from step, opcode and CON_output.
- Unlisted outputs are 0 in every step. operation is 0 unless stated.
- Opcode map:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, and 00101, or 00110
  - ror 00111, rol 01000, shr 01001, shra 01010, shl 01011
  - addi 01100, andi 01101, ori 01110
  - div 01111, mul 10000, neg 10001, not 10010
  - br 10011, jr 10100, jal 10101, in 10110, out 10111
  - mflo 11000, mfhi 11001, nop 11010, halt 11011
  - 11100–11111 execute as nop.
- Fetch:
  - T0: PCout, MAR_enable, IncPC.
  - T1: Read, MDR_enable.
  - T2: MDRout, IR_enable.
- Register ALU ops (add..shl):
  - T3: GRB Rout Y_enable.
  - T4: GRC Rout, operation=opcode, Z_low_enable.
  - T5: ZLowout GRA Rin.
- Immediate ops (addi/andi/ori): same as register ALU ops, but T4 uses Cout instead of GRC Rout.
- neg/not:
  - T3: GRB Rout, operation=opcode, Z_low_enable.
  - T4: ZLowout GRA Rin.
- mul/div:
  - T3: GRA Rout Y_enable.
  - T4: GRB Rout, operation=opcode, Z_low_enable, Z_high_enable.
  - T5: ZLowout LO_enable.
  - T6: ZHighout HI_enable.
- ld, ldi, st share T3–T4:
  - T3: GRB BAout Y_enable.
  - T4: Cout, operation=ADD_OP, Z_low_enable.
- ldi: T5: ZLowout GRA Rin.
- ld:
  - T5: ZLowout MAR_enable.
  - T6: Read MDR_enable.
  - T7: MDRout GRA Rin.
- st:
  - T5: ZLowout MAR_enable.
  - T6: GRA Rout MDR_enable (Read=0, so MDR loads from the bus).
  - T7: Write.
- br:
  - T3: GRA Rout CON_in.
  - T4: PCout Y_enable.
  - T5: Cout, operation=ADD_OP, Z_low_enable.
  - T6: ZLowout, plus PC_enable only if CON_output=1.
- jr: T3: GRA Rout PC_enable.
- jal:
  - T3: PCout R15_enable.
  - T4: GRA Rout PC_enable.
  - With Ra=R15, jal jumps to the just-saved return address.
- Single-step ops (T3 only):
  - in: InPortout GRA Rin.
  - out: GRA Rout Output_port_enable.
  - mfhi: HIout GRA Rin.
  - mflo: LOout GRA Rin.
- nop: T3 drives no outputs.
- halt: T3 → HALT.
- After the last execute step of an instruction, the next state is T0.
- HALT:
  - All strobes are 0 and run=0.
  - HALT is left only by reset.
- stop handling:
  - stop is sampled only on the edge leaving the last execute step; if high, next state is HALT instead of T0.
  - stop high mid-instruction never truncates the instruction.

## Timing
- Reset: clear=0 at a rising edge → step=T0, run=1. While clear=0, all outputs are forced to 0 (run included).
- Reset applied mid-instruction abandons the instruction. The first cycle after release is T0.
- Instruction cycle counts (fetch included):
  - nop, jr, in, out, mfhi, mflo: 4
  - jal, neg, not: 5
  - add..ori, ldi: 6
  - br, mul, div: 7
  - ld, st: 8
  - halt: 4 cycles, then HALT.
- IR is sampled combinationally. The IR value loaded at the end of T2 governs T3 onward.
- CON_output is first valid in T4 and is consumed in T6.
- Read and MDR_enable are asserted in the same cycle: memory read latency is one cycle.

## Test plan
- Reset then add R5,R2,R4 (IR=0x1A920000) → T0–T5 strobes match the add sequence exactly, operation=00011 only in T4, back at T0 after 6 cycles.
- ld R1,0x55(R0) (IR=0x00800055) → BAout in T3, Cout and operation=00011 in T4, Read+MDR_enable in both T1 and T6, GRA Rin in T7, cycle count 8.
- br taken vs not (IR=0x99980009 with CON_output=1, then 0) → PC_enable in T6 only when CON_output=1. ZLowout is asserted in both cases.
- mul R3,R1 (IR=0x81880000) → LO_enable in T5 and HI_enable in T6, never together; Z_low_enable and Z_high_enable both asserted in T4.
- stop asserted during T4 of add → instruction completes through T5, then HALT with run=0. A halt opcode (0xD8000000) also reaches HALT after T3.
- clear driven low during T6 of st → Write never asserted. After release, T0 with PCout+MAR_enable+IncPC on the first cycle.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit bus CPU: step counter (T0..T7, HALT)
// plus opcode decode. Every datapath strobe is a Moore-style decode of the
// current step, the IR opcode and the CON flip-flop result.
module control_sequencer #(
  parameter logic [4:0] ADD_OP = 5'b00011
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_output,
  input  logic        stop,
  // Bus sources
  output logic        PCout,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        InPortout,
  // Register loads
  output logic        MAR_enable,
  output logic        PC_enable,
  output logic        IncPC,
  output logic        MDR_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_low_enable,
  output logic        Z_high_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        Output_port_enable,
  output logic        R15_enable,
  // Memory strobes
  output logic        Read,
  output logic        Write,
  // Register-select fields
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CON_in,
  // ALU and status
  output logic [4:0]  operation,
  output logic        run
);

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpJal  = 5'b10101;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMflo = 5'b11000;
  localparam logic [4:0] OpMfhi = 5'b11001;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    StT0   = 4'd0,
    StT1   = 4'd1,
    StT2   = 4'd2,
    StT3   = 4'd3,
    StT4   = 4'd4,
    StT5   = 4'd5,
    StT6   = 4'd6,
    StT7   = 4'd7,
    StHalt = 4'd8
  } step_e;

  step_e      step_q, step_d;
  step_e      last_step;
  logic [4:0] opcode;

  assign opcode = IR[31:27];

  // Register fields are decoded inside the datapath, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^IR[26:0];

  // Final execute step of the current opcode; reserved opcodes behave as nop.
  always_comb begin
    last_step = StT3;
    case (opcode) inside
      OpLd, OpSt:                 last_step = StT7;
      OpLdi, [OpAdd:OpOri]:       last_step = StT5;
      OpBr, OpMul, OpDiv:         last_step = StT6;
      OpJal, OpNeg, OpNot:        last_step = StT4;
      default:                    last_step = StT3;
    endcase
  end

  // Step sequencing: fetch, execute to the opcode's last step, then T0 or HALT.
  always_comb begin
    step_d = step_q;
    case (step_q)
      StT0:   step_d = StT1;
      StT1:   step_d = StT2;
      StT2:   step_d = StT3;
      StHalt: step_d = StHalt;
      default: begin
        if (step_q == StT3 && opcode == OpHalt) begin
          step_d = StHalt;
        end else if (step_q >= last_step) begin
          // >= also recovers if IR changes mid-instruction and shortens it.
          step_d = stop ? StHalt : StT0;
        end else begin
          step_d = step_e'(step_q + 4'd1);
        end
      end
    endcase
  end

  // Step register with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!clear) begin
      step_q <= StT0;
    end else begin
      step_q <= step_d;
    end
  end

  assign run = clear && (step_q != StHalt);

  // Strobe decode; everything is held low while clear is asserted.
  always_comb begin
    PCout              = 1'b0;
    ZLowout            = 1'b0;
    ZHighout           = 1'b0;
    MDRout             = 1'b0;
    HIout              = 1'b0;
    LOout              = 1'b0;
    Cout               = 1'b0;
    InPortout          = 1'b0;
    MAR_enable         = 1'b0;
    PC_enable          = 1'b0;
    IncPC              = 1'b0;
    MDR_enable         = 1'b0;
    IR_enable          = 1'b0;
    Y_enable           = 1'b0;
    Z_low_enable       = 1'b0;
    Z_high_enable      = 1'b0;
    HI_enable          = 1'b0;
    LO_enable          = 1'b0;
    Output_port_enable = 1'b0;
    R15_enable         = 1'b0;
    Read               = 1'b0;
    Write              = 1'b0;
    GRA                = 1'b0;
    GRB                = 1'b0;
    GRC                = 1'b0;
    Rin                = 1'b0;
    Rout               = 1'b0;
    BAout              = 1'b0;
    CON_in             = 1'b0;
    operation          = 5'd0;

    if (clear) begin
      case (step_q)
        StT0: begin
          PCout      = 1'b1;
          MAR_enable = 1'b1;
          IncPC      = 1'b1;
        end
        StT1: begin
          Read       = 1'b1;
          MDR_enable = 1'b1;
        end
        StT2: begin
          MDRout    = 1'b1;
          IR_enable = 1'b1;
        end
        StT3: begin
          case (opcode) inside
            OpLd, OpLdi, OpSt: begin
              GRB      = 1'b1;
              BAout    = 1'b1;
              Y_enable = 1'b1;
            end
            [OpAdd:OpOri]: begin
              GRB      = 1'b1;
              Rout     = 1'b1;
              Y_enable = 1'b1;
            end
            OpNeg, OpNot: begin
              GRB          = 1'b1;
              Rout         = 1'b1;
              operation    = opcode;
              Z_low_enable = 1'b1;
            end
            OpMul, OpDiv: begin
              GRA      = 1'b1;
              Rout     = 1'b1;
              Y_enable = 1'b1;
            end
            OpBr: begin
              GRA    = 1'b1;
              Rout   = 1'b1;
              CON_in = 1'b1;
            end
            OpJr: begin
              GRA       = 1'b1;
              Rout      = 1'b1;
              PC_enable = 1'b1;
            end
            OpJal: begin
              PCout      = 1'b1;
              R15_enable = 1'b1;
            end
            OpIn: begin
              InPortout = 1'b1;
              GRA       = 1'b1;
              Rin       = 1'b1;
            end
            OpOut: begin
              GRA                = 1'b1;
              Rout               = 1'b1;
              Output_port_enable = 1'b1;
            end
            OpMfhi: begin
              HIout = 1'b1;
              GRA   = 1'b1;
              Rin   = 1'b1;
            end
            OpMflo: begin
              LOout = 1'b1;
              GRA   = 1'b1;
              Rin   = 1'b1;
            end
            default: ;
          endcase
        end
        StT4: begin
          case (opcode) inside
            OpLd, OpLdi, OpSt: begin
              Cout         = 1'b1;
              operation    = ADD_OP;
              Z_low_enable = 1'b1;
            end
            [OpAdd:OpShl]: begin
              GRC          = 1'b1;
              Rout         = 1'b1;
              operation    = opcode;
              Z_low_enable = 1'b1;
            end
            [OpAddi:OpOri]: begin
              Cout         = 1'b1;
              operation    = opcode;
              Z_low_enable = 1'b1;
            end
            OpNeg, OpNot: begin
              ZLowout = 1'b1;
              GRA     = 1'b1;
              Rin     = 1'b1;
            end
            OpMul, OpDiv: begin
              GRB           = 1'b1;
              Rout          = 1'b1;
              operation     = opcode;
              Z_low_enable  = 1'b1;
              Z_high_enable = 1'b1;
            end
            OpBr: begin
              PCout    = 1'b1;
              Y_enable = 1'b1;
            end
            OpJal: begin
              GRA       = 1'b1;
              Rout      = 1'b1;
              PC_enable = 1'b1;
            end
            default: ;
          endcase
        end
        StT5: begin
          case (opcode) inside
            OpLdi, [OpAdd:OpOri]: begin
              ZLowout = 1'b1;
              GRA     = 1'b1;
              Rin     = 1'b1;
            end
            OpLd, OpSt: begin
              ZLowout    = 1'b1;
              MAR_enable = 1'b1;
            end
            OpMul, OpDiv: begin
              ZLowout   = 1'b1;
              LO_enable = 1'b1;
            end
            OpBr: begin
              Cout         = 1'b1;
              operation    = ADD_OP;
              Z_low_enable = 1'b1;
            end
            default: ;
          endcase
        end
        StT6: begin
          case (opcode) inside
            OpLd: begin
              Read       = 1'b1;
              MDR_enable = 1'b1;
            end
            OpSt: begin
              // Read stays low so MDR takes its value from the bus.
              GRA        = 1'b1;
              Rout       = 1'b1;
              MDR_enable = 1'b1;
            end
            OpMul, OpDiv: begin
              ZHighout  = 1'b1;
              HI_enable = 1'b1;
            end
            OpBr: begin
              ZLowout   = 1'b1;
              PC_enable = CON_output;
            end
            default: ;
          endcase
        end
        StT7: begin
          case (opcode) inside
            OpLd: begin
              MDRout = 1'b1;
              GRA    = 1'b1;
              Rin    = 1'b1;
            end
            OpSt: begin
              Write = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
